// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Arbitrates NREQ divide requesters onto one shared unsigned divider. Only one
// divide is in flight at a time. Requesters are granted round-robin, starting
// just above the most recently issued requester. Each result comes back on a
// single response bus, tagged with the requester id.
//
// Optional feature (macro DIV_SCHED_TIMEOUT_EN):
//   When defined, a WAIT-cycle counter is built. If the divider is silent for
//   TIMEOUT cycles, the divide is abandoned and a response with rsp_tmo = 1 is
//   returned. When undefined, rsp_tmo is tied low and WAIT lasts until
//   div_done arrives.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_valid[NREQ]   per-requester request
//   req_a, req_b      packed dividends / divisors, lane i at [i*WIDTH +: WIDTH]
//   req_ready[NREQ]   one-hot acceptance pulse (combinational, IDLE only)
//   rsp_valid         response present (RESP state)
//   rsp_id            requester id of the response
//   rsp_val           quotient; forced to 0 whenever a flag is set
//   rsp_dbz/ovf/tmo   divide-by-zero / overflow / timeout flags
//   rsp_ready         consumer accepts the response
//   div_start         one-cycle start strobe to the divider
//   div_a, div_b      operands to the divider, held through WAIT
//   div_done, div_valid, div_val, div_dbz, div_ovf   divider status/result
// -----------------------------------------------------------------------------
module div_sched #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FBITS   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_val,
  output logic                    rsp_dbz,
  output logic                    rsp_ovf,
  output logic                    rsp_tmo,
  input  logic                    rsp_ready,
  output logic                    div_start,
  output logic [WIDTH-1:0]        div_a,
  output logic [WIDTH-1:0]        div_b,
  input  logic                    div_done,
  input  logic                    div_valid,
  input  logic                    div_dbz,
  input  logic                    div_ovf,
  input  logic [WIDTH-1:0]        div_val
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;

  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_val_q, rsp_val_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             any_valid;
  logic [IDW-1:0]   grant_idx;
  int unsigned      cand;
  logic             tmo_hit;

  // div_valid carries no information beyond div_done and the flags, and FBITS
  // only describes the data format; both are intentionally not interpreted.
  logic unused_ok;
  assign unused_ok = ^{div_valid, 1'(FBITS & 1), 1'(TIMEOUT & 1)};

  // Round-robin pick: first valid requester strictly above last_grant, wrapping.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(last_grant_q) + off) % NREQ;
      if (!any_valid && req_valid[cand[IDW-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // Optional WAIT timeout.
`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rsp_tmo_q, rsp_tmo_d;

  // The counter is 0 in the first WAIT cycle, so expiry lands on WAIT cycle TIMEOUT.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  assign tmo_hit = (state_q == S_WAIT) && (cnt_q == CNTW'(TIMEOUT - 1));

  // A div_done in the expiry cycle takes priority over the timeout.
  always_comb begin
    rsp_tmo_d = rsp_tmo_q;
    if (state_q == S_WAIT) begin
      if (div_done) begin
        rsp_tmo_d = 1'b0;
      end else if (tmo_hit) begin
        rsp_tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rsp_tmo_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_tmo_q <= rsp_tmo_d;
    end
  end

  assign rsp_tmo = rsp_tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_tmo = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (div_done || tmo_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. req_ready is gated by rst so it stays low while reset is held.
  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  if (any_valid && !rst) req_ready = NREQ'(1) << grant_idx;
      S_ISSUE: div_start = 1'b1;
      S_WAIT:  ;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: operand capture, grant history, response latch.
  always_comb begin
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_val_d    = rsp_val_q;
    rsp_dbz_d    = rsp_dbz_q;
    rsp_ovf_d    = rsp_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          gnt_id_d = grant_idx;
          op_a_d   = req_a[32'(grant_idx)*WIDTH +: WIDTH];
          op_b_d   = req_b[32'(grant_idx)*WIDTH +: WIDTH];
        end
      end
      S_ISSUE: begin
        last_grant_d = gnt_id_q;
      end
      S_WAIT: begin
        if (div_done) begin
          rsp_id_d  = gnt_id_q;
          rsp_dbz_d = div_dbz;
          rsp_ovf_d = div_ovf;
          rsp_val_d = (div_dbz || div_ovf) ? '0 : div_val;
        end else if (tmo_hit) begin
          rsp_id_d  = gnt_id_q;
          rsp_dbz_d = 1'b0;
          rsp_ovf_d = 1'b0;
          rsp_val_d = '0;
        end
      end
      S_RESP: ;
      default: ;
    endcase
  end

  // Datapath registers. last_grant resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_id_q     <= '0;
      rsp_val_q    <= '0;
      rsp_dbz_q    <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_val_q    <= rsp_val_d;
      rsp_dbz_q    <= rsp_dbz_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign div_a   = op_a_q;
  assign div_b   = op_b_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_val = rsp_val_q;
  assign rsp_dbz = rsp_dbz_q;
  assign rsp_ovf = rsp_ovf_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched (WIDTH=8, FBITS=4, NREQ=4, TIMEOUT=16) with a
// behavioural fixed-point divider of programmable latency.
module tb_div_sched;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned FBITS   = 4;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_val;
  logic                  rsp_dbz, rsp_ovf, rsp_tmo;
  logic                  rsp_ready;
  logic                  div_start;
  logic [WIDTH-1:0]      div_a, div_b, div_val;
  logic                  div_done, div_valid, div_dbz, div_ovf;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  int n2;
  int exp_g[6] = '{0, 1, 2, 3, 0, 1};

  // Divider model controls
  int unsigned k_lat = 1;
  logic        hang = 1'b0;
  logic        force_done = 1'b0;

  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  int unsigned      m_cnt = 0;
  logic [15:0]      m_num, m_q;

  div_sched #(
    .WIDTH(WIDTH), .FBITS(FBITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_val(rsp_val),
    .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .rsp_tmo(rsp_tmo), .rsp_ready(rsp_ready),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_valid(div_valid), .div_dbz(div_dbz),
    .div_ovf(div_ovf), .div_val(div_val)
  );

  always #5 clk = ~clk;

  // Divider: done k_lat cycles after the div_start cycle.
  always @(posedge clk) begin
    if (div_start) begin
      m_a   <= div_a;
      m_b   <= div_b;
      m_cnt <= k_lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    m_num     = 16'(m_a) << FBITS;
    m_q       = (m_b == '0) ? 16'h0 : m_num / 16'(m_b);
    div_dbz   = (m_b == '0);
    div_ovf   = !div_dbz && (m_q > 16'h00FF);
    div_val   = div_dbz ? 8'hFF : m_q[7:0];
    div_done  = ((m_cnt == 1) && !hang) || force_done;
    div_valid = div_done && !div_dbz && !div_ovf;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int maxc, output int cnt);
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < maxc) begin
      @(negedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: everything low, even with all requests valid
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_div_a", 32'(div_a), 0);
    chk("rst_div_b", 32'(div_b), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_val", 32'(rsp_val), 0);
    chk("rst_rsp_dbz", 32'(rsp_dbz), 0);
    chk("rst_rsp_ovf", 32'(rsp_ovf), 0);
    chk("rst_rsp_tmo", 32'(rsp_tmo), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_no_req", 32'(req_ready), 0);

    // A: requester 2, 0x30/0x20 -> 0x18, k=3
    set_lane(2, 8'h30, 8'h20); k_lat = 3; req_valid = 4'b0100; #1;
    chk("A_grant", 32'(req_ready), 32'h4);
    step();
    chk("A_start", 32'(div_start), 1);
    chk("A_div_a", 32'(div_a), 32'h30);
    chk("A_div_b", 32'(div_b), 32'h20);
    chk("A_no_ready_issue", 32'(req_ready), 0);
    req_valid = '0;
    step();
    chk("A_start_one_cycle", 32'(div_start), 0);
    chk("A_div_a_hold", 32'(div_a), 32'h30);
    wait_rsp(50, n);
    chk("A_latency", 32'(n + 1), 4);
    chk("A_id", 32'(rsp_id), 2);
    chk("A_val", 32'(rsp_val), 32'h18);
    chk("A_dbz", 32'(rsp_dbz), 0);
    chk("A_ovf", 32'(rsp_ovf), 0);
    chk("A_tmo", 32'(rsp_tmo), 0);
    step();
    chk("A_rsp_cleared", 32'(rsp_valid), 0);

    // B: requester 1, divide by zero; a div_done during ISSUE must be ignored
    set_lane(1, 8'h55, 8'h00); k_lat = 2; req_valid = 4'b0010; #1;
    chk("B_grant", 32'(req_ready), 32'h2);
    step();
    force_done = 1'b1; req_valid = '0; #1;
    chk("B_start", 32'(div_start), 1);
    @(negedge clk);
    force_done = 1'b0; #1;
    wait_rsp(50, n);
    chk("B_latency", 32'(n), 2);
    chk("B_id", 32'(rsp_id), 1);
    chk("B_dbz", 32'(rsp_dbz), 1);
    chk("B_val", 32'(rsp_val), 0);
    chk("B_ovf", 32'(rsp_ovf), 0);
    step();

    // C: requester 3, 0xF0/0x01 overflows Q4.4
    set_lane(3, 8'hF0, 8'h01); k_lat = 1; req_valid = 4'b1000; #1;
    chk("C_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    wait_rsp(50, n);
    chk("C_latency", 32'(n), 2);
    chk("C_id", 32'(rsp_id), 3);
    chk("C_ovf", 32'(rsp_ovf), 1);
    chk("C_val", 32'(rsp_val), 0);
    chk("C_dbz", 32'(rsp_dbz), 0);
    step();

    // Fairness: all valid, grants 0,1,2,3,0,1 with no pulse between grants
    for (int i = 0; i < 4; i++) set_lane(i, 8'h40, 8'h20);
    k_lat = 1; req_valid = 4'b1111; #1;
    for (int t = 0; t < 6; t++) begin
      n2 = 0;
      while (req_ready == '0 && n2 < 20) begin
        step();
        n2++;
      end
      chk($sformatf("F_grant%0d", t), 32'(req_ready), 32'(1) << exp_g[t]);
      if (t > 0) chk($sformatf("F_gap%0d", t), 32'(n2), 3);
      step();
    end
    req_valid = '0;
    wait_rsp(50, n);
    chk("F_last_id", 32'(rsp_id), 1);
    chk("F_last_val", 32'(rsp_val), 32'h20);
    step();

    // D: back-pressure for 10 cycles, request kept valid, no new grant
    rsp_ready = 1'b0;
    set_lane(0, 8'h10, 8'h40); k_lat = 1; req_valid = 4'b0001; #1;
    chk("D_grant", 32'(req_ready), 32'h1);
    step();
    wait_rsp(50, n);
    chk("D_latency", 32'(n), 2);
    for (int i = 0; i < 10; i++) begin
      chk("D_hold_valid", 32'(rsp_valid), 1);
      chk("D_hold_id", 32'(rsp_id), 0);
      chk("D_hold_val", 32'(rsp_val), 32'h04);
      chk("D_hold_dbz", 32'(rsp_dbz), 0);
      chk("D_hold_no_grant", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1; #1;
    chk("D_hs_no_grant", 32'(req_ready), 0);
    step();
    chk("D_rsp_cleared", 32'(rsp_valid), 0);
    chk("D_next_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    wait_rsp(50, n);
    chk("D2_id", 32'(rsp_id), 0);
    step();

    // E: divider never answers
    hang = 1'b1;
    set_lane(2, 8'h01, 8'h01); req_valid = 4'b0100; #1;
    chk("E_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("E_start", 32'(div_start), 1);
`ifdef DIV_SCHED_TIMEOUT_EN
    wait_rsp(100, n);
    chk("E_tmo_latency", 32'(n), TIMEOUT + 1);
    chk("E_tmo", 32'(rsp_tmo), 1);
    chk("E_tmo_val", 32'(rsp_val), 0);
    chk("E_tmo_dbz", 32'(rsp_dbz), 0);
    chk("E_tmo_ovf", 32'(rsp_ovf), 0);
    chk("E_tmo_id", 32'(rsp_id), 2);
    step();
    chk("E_rsp_cleared", 32'(rsp_valid), 0);
    set_lane(3, 8'h01, 8'h01); req_valid = 4'b1000; #1;
    chk("E_grant2", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    repeat (3) step();
`else
    repeat (40) step();
    chk("E_stuck_no_rsp", 32'(rsp_valid), 0);
    chk("E_stuck_tmo", 32'(rsp_tmo), 0);
    req_valid = 4'b1111; #1;
    chk("E_stuck_no_grant", 32'(req_ready), 0);
    req_valid = '0;
    step();
`endif

    // F: reset mid-WAIT, late div_done ignored, requester 0 first afterwards
    rst = 1'b1; req_valid = '1; #1;
    chk("F_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("F_rst_div_start", 32'(div_start), 0);
    chk("F_rst_div_a", 32'(div_a), 0);
    chk("F_rst_req_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0; req_valid = '0;
    step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    chk("F_late_done_0", 32'(rsp_valid), 0);
    step();
    chk("F_late_done_1", 32'(rsp_valid), 0);
    step();
    chk("F_late_done_2", 32'(rsp_valid), 0);
    hang = 1'b0;
    set_lane(0, 8'h20, 8'h10);
    req_valid = 4'b1111; #1;
    chk("F_first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    wait_rsp(50, n);
    chk("F_rsp_id", 32'(rsp_id), 0);
    chk("F_rsp_val", 32'(rsp_val), 32'h20);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
